neopixel_bit_encoder: RTL

NEOPIXEL_BIT_ENCODER -- requirements
Module: neopixel_bit_encoder

---
 rtl/neopixel_bit_encoder.sv | 75 +++++++
 1 files changed

// File: rtl/neopixel_bit_encoder.sv
// neopixel_bit_encoder: serialises bytes MSB-first into NRZ bit codes with per-bit latched high/period times
module neopixel_bit_encoder (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] reg_t0h_time_i,
    input  logic [8:0] reg_t0s_time_i,
    input  logic [7:0] reg_t1h_time_i,
    input  logic [8:0] reg_t1s_time_i,
    input  logic       data_vld_i,
    input  logic [7:0] data_i,
    output logic       data_rdy_o,
    output logic       bit_code_o,
    output logic       busy_o
);
    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;
    logic       r_state;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic [8:0] r_cnt;
    logic [7:0] r_th;
    logic [8:0] r_ts;
    logic       r_code;
    logic       w_last;
    logic       w_hs;
    logic       w_nbit;
    logic [7:0] w_th;
    logic [8:0] w_ts;
    logic [8:0] w_cnt_nx;
    assign w_last     = (r_state == SEND) && (r_cnt == r_ts);
    assign data_rdy_o = (r_state == IDLE) || (w_last && r_idx == 3'd0);
    assign w_hs       = data_vld_i && data_rdy_o;
    // value of the bit about to start: new byte MSB or the next shifted bit
    assign w_nbit     = w_hs ? data_i[7] : r_shift[6];
    assign w_th       = w_nbit ? reg_t1h_time_i : reg_t0h_time_i;
    assign w_ts       = w_nbit ? reg_t1s_time_i : reg_t0s_time_i;
    assign w_cnt_nx   = r_cnt + 9'd1;
    assign busy_o     = r_state == SEND;
    assign bit_code_o = r_code;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_shift <= 8'h00;
            r_idx   <= 3'd0;
            r_cnt   <= 9'd0;
            r_th    <= 8'd0;
            r_ts    <= 9'd0;
            r_code  <= 1'b0;
        end else if (w_hs) begin
            r_state <= SEND;
            r_shift <= data_i;
            r_idx   <= 3'd7;
            r_cnt   <= 9'd0;
            r_th    <= w_th;
            r_ts    <= w_ts;
            r_code  <= 1'b1;
        end else if (w_last) begin
            if (r_idx != 3'd0) begin
                r_idx   <= r_idx - 3'd1;
                r_shift <= {r_shift[6:0], 1'b0};
                r_cnt   <= 9'd0;
                r_th    <= w_th;
                r_ts    <= w_ts;
                r_code  <= 1'b1;
            end else begin
                r_state <= IDLE;
                r_cnt   <= 9'd0;
                r_code  <= 1'b0;
            end
        end else if (r_state == SEND) begin
            r_cnt  <= w_cnt_nx;
            r_code <= w_cnt_nx <= {1'b0, r_th};
        end
    end
endmodule
